seg7_scan_display: RTL and testbench

SEG7_SCAN_DISPLAY -- requirements
Module: seg7_scan_display

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_scan_display_if.sv | 13 +
 rtl/seg7_decode.sv | 27 ++
 rtl/seg7_scan_display.sv | 100 ++++++++++
 tb/tb_seg7_scan_display.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared segment encodings and helpers for the multiplexed 4-digit 7-segment driver.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

   localparam logic [6:0] SEG_0    = 7'h40;
   localparam logic [6:0] SEG_1    = 7'h79;
   localparam logic [6:0] SEG_2    = 7'h24;
   localparam logic [6:0] SEG_3    = 7'h30;
   localparam logic [6:0] SEG_4    = 7'h19;
   localparam logic [6:0] SEG_5    = 7'h12;
   localparam logic [6:0] SEG_6    = 7'h02;
   localparam logic [6:0] SEG_7    = 7'h78;
   localparam logic [6:0] SEG_8    = 7'h00;
   localparam logic [6:0] SEG_9    = 7'h10;
   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   localparam int unsigned CNT_W = 16;

   // Leading zeros only; a non-BCD nibble is never counted as zero, and digit 0 always shows.
   function automatic logic [3:0] lead_zero_mask(input logic [15:0] d);
      logic [3:0] m;
      m[3] = (d[15:12] == 4'd0);
      m[2] = m[3] && (d[11:8] == 4'd0);
      m[1] = m[2] && (d[7:4] == 4'd0);
      m[0] = 1'b0;
      return m;
   endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Bundle of the display data inputs and the scanned pin outputs of seg7_scan_display.
interface seg7_scan_display_if;

   logic [15:0] digits;
   logic        blank;
   logic [6:0]  seg_n;
   logic [3:0]  an_n;
   logic        frame_start;

   modport master (output digits, output blank, input seg_n, input an_n, input frame_start);
   modport slave  (input digits, input blank, output seg_n, output an_n, output frame_start);

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 show a dash.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_n_o
);

   // Digit lookup
   always_comb begin
      seg_n_o = SEG_DASH;
      case (bcd_i)
         4'd0:    seg_n_o = SEG_0;
         4'd1:    seg_n_o = SEG_1;
         4'd2:    seg_n_o = SEG_2;
         4'd3:    seg_n_o = SEG_3;
         4'd4:    seg_n_o = SEG_4;
         4'd5:    seg_n_o = SEG_5;
         4'd6:    seg_n_o = SEG_6;
         4'd7:    seg_n_o = SEG_7;
         4'd8:    seg_n_o = SEG_8;
         4'd9:    seg_n_o = SEG_9;
         default: seg_n_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 4-digit 7-segment scanner with per-frame shadow capture and ghost cycles.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int unsigned DIV = 1000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] digits,
   input  logic        blank,
   output logic [6:0]  seg_n,
   output logic [3:0]  an_n,
   output logic        frame_start
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [15:0]      shadow_q, shadow_d;
   logic [6:0]       seg_n_q, seg_n_d;
   logic [3:0]       an_n_q, an_n_d;
   logic             frame_start_q, frame_start_d;
   logic             tick_s;
   logic             wrap_s;
   logic [3:0]       digit_s;
   logic [6:0]       dec_seg_s;
   logic [3:0]       lzb_mask_s;

   // Pins are driven from the state being entered, so the ghost cycle lands on the slot's first cycle
   always_comb begin
      tick_s        = (cnt_q == CNT_LAST);
      wrap_s        = tick_s && (idx_q == 2'd3);
      cnt_d         = cnt_q + CNT_ONE;
      idx_d         = idx_q;
      shadow_d      = shadow_q;
      an_n_d        = 4'hF;
      seg_n_d       = SEG_OFF;
      frame_start_d = (cnt_q == {CNT_W{1'b0}}) && (idx_q == 2'd0);
      if (tick_s) begin
         cnt_d = {CNT_W{1'b0}};
         idx_d = idx_q + 2'd1;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
         idx_d = idx_q;
      end
      if (wrap_s) begin
         shadow_d = digits;
      end else begin
         shadow_d = shadow_q;
      end
      digit_s = shadow_d[{idx_d, 2'b00} +: 4];
`ifdef SEG7_LZB_EN
      lzb_mask_s = lead_zero_mask(shadow_d);
`else
      lzb_mask_s = 4'b0000;
`endif
      if (lzb_mask_s[idx_d]) begin
         seg_n_d = SEG_OFF;
      end else begin
         seg_n_d = dec_seg_s;
      end
      if (blank || (cnt_d == {CNT_W{1'b0}})) begin
         an_n_d = 4'hF;
      end else begin
         an_n_d = ~(4'b0001 << idx_d);
      end
   end

   seg7_decode u_decode (
      .bcd_i   (digit_s),
      .seg_n_o (dec_seg_s)
   );

   // Reset parks the scanner on the last cycle of digit 3 so the first live edge starts a frame
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q         <= CNT_LAST;
         idx_q         <= 2'd3;
         shadow_q      <= 16'h0000;
         seg_n_q       <= SEG_OFF;
         an_n_q        <= 4'hF;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         shadow_q      <= shadow_d;
         seg_n_q       <= seg_n_d;
         an_n_q        <= an_n_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign seg_n       = seg_n_q;
   assign an_n        = an_n_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display (DIV = 4): fixed vector table, directed corner
// sequences and randomized digits/blank against a slot-arithmetic reference model.
module tb_seg7_scan_display;

   localparam int DIV = 4;
   localparam int FRAME = 4 * DIV;

   logic clk = 1'b0;
   logic reset_n;

   seg7_scan_display_if bus();

   seg7_scan_display #(.DIV(DIV)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .digits      (bus.digits),
      .blank       (bus.blank),
      .seg_n       (bus.seg_n),
      .an_n        (bus.an_n),
      .frame_start (bus.frame_start)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [6:0]  seg_tab [16];
   int          t;
   logic [15:0] shadow_m;
   logic [3:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_fs;

   typedef struct {
      logic [15:0] digits;
      logic        blank;
      logic [3:0]  an;
      logic [6:0]  seg;
      logic        fs;
   } vec_t;

   vec_t tab [18];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, t);
      end
   endtask

   function automatic logic digit_blanked(input logic [15:0] d, input int i);
`ifdef SEG7_LZB_EN
      if (i == 0) return 1'b0;
      for (int j = i; j < 4; j++) begin
         if (((d >> (4 * j)) & 16'h000F) != 16'h0000) return 1'b0;
      end
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      t        = 0;
      shadow_m = 16'h0000;
      exp_an   = 4'hF;
      exp_seg  = 7'h7F;
      exp_fs   = 1'b0;
   endtask

   // Edge number since reset release -> slot, position in slot, digit, frame boundary
   task automatic model_edge(input logic [15:0] dig, input logic blk);
      int pos;
      int idx;
      logic [3:0] one;
      logic [15:0] nib;
      one = 4'b0001;
      t++;
      pos = (t - 1) % DIV;
      idx = ((t - 1) / DIV) % 4;
      if (((t - 1) % FRAME) == 0) shadow_m = dig;
      nib     = (shadow_m >> (4 * idx)) & 16'h000F;
      exp_an  = (blk || pos == 0) ? 4'hF : ~(one << idx);
      exp_seg = digit_blanked(shadow_m, idx) ? 7'h7F : seg_tab[nib[3:0]];
      exp_fs  = (((t - 1) % FRAME) == 1);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(bus.digits, bus.blank);
      #1;
      check("model_an", {12'h000, bus.an_n}, {12'h000, exp_an});
      check("model_seg", {9'h000, bus.seg_n}, {9'h000, exp_seg});
      check("model_fs", {15'h0000, bus.frame_start}, {15'h0000, exp_fs});
   endtask

   task automatic run_to(input int target);
      while (t < target) step();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_an"}, {12'h000, bus.an_n}, 16'h000F);
      check({tag, "_seg"}, {9'h000, bus.seg_n}, 16'h007F);
      check({tag, "_fs"}, {15'h0000, bus.frame_start}, 16'h0000);
   endtask

   task automatic run_table();
      for (int i = 0; i < 18; i++) begin
         bus.digits = tab[i].digits;
         bus.blank  = tab[i].blank;
         step();
         check("tab_an", {12'h000, bus.an_n}, {12'h000, tab[i].an});
         check("tab_seg", {9'h000, bus.seg_n}, {9'h000, tab[i].seg});
         check("tab_fs", {15'h0000, bus.frame_start}, {15'h0000, tab[i].fs});
      end
   endtask

   initial begin
      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
      tab[0]  = '{16'h1234, 1'b0, 4'hF, 7'h19, 1'b0};
      tab[1]  = '{16'h1234, 1'b0, 4'hE, 7'h19, 1'b1};
      tab[2]  = '{16'h1234, 1'b0, 4'hE, 7'h19, 1'b0};
      tab[3]  = '{16'h1234, 1'b0, 4'hE, 7'h19, 1'b0};
      tab[4]  = '{16'h1234, 1'b0, 4'hF, 7'h30, 1'b0};
      tab[5]  = '{16'h1234, 1'b0, 4'hD, 7'h30, 1'b0};
      tab[6]  = '{16'h1234, 1'b0, 4'hD, 7'h30, 1'b0};
      tab[7]  = '{16'h1234, 1'b0, 4'hD, 7'h30, 1'b0};
      tab[8]  = '{16'h1234, 1'b0, 4'hF, 7'h24, 1'b0};
      tab[9]  = '{16'h1234, 1'b0, 4'hB, 7'h24, 1'b0};
      tab[10] = '{16'h1234, 1'b0, 4'hB, 7'h24, 1'b0};
      tab[11] = '{16'h1234, 1'b0, 4'hB, 7'h24, 1'b0};
      tab[12] = '{16'h1234, 1'b0, 4'hF, 7'h79, 1'b0};
      tab[13] = '{16'h1234, 1'b0, 4'h7, 7'h79, 1'b0};
      tab[14] = '{16'h1234, 1'b0, 4'h7, 7'h79, 1'b0};
      tab[15] = '{16'h1234, 1'b0, 4'h7, 7'h79, 1'b0};
      tab[16] = '{16'h1234, 1'b0, 4'hF, 7'h19, 1'b0};
      tab[17] = '{16'h1234, 1'b0, 4'hE, 7'h19, 1'b1};

      // Reset held across several edges, then released between edges
      reset_n    = 1'b0;
      bus.digits = 16'h1234;
      bus.blank  = 1'b0;
      model_reset();
      #23;
      check_reset_vals("reset");
      @(posedge clk);
      #1;
      check_reset_vals("reset_hold");
      reset_n = 1'b1;
      run_table();

      // Digits change during the digit-1 slot; the running frame keeps 1234
      run_to(21);
      bus.digits = 16'h5678;
      step();
      check("tear_seg_d1", {9'h000, bus.seg_n}, 16'h0030);
      run_to(29);
      check("tear_seg_d3", {9'h000, bus.seg_n}, 16'h0079);
      run_to(33);
      check("tear_seg_new", {9'h000, bus.seg_n}, 16'h0000);
      step();
      check("tear_fs", {15'h0000, bus.frame_start}, 16'h0001);
      check("tear_an", {12'h000, bus.an_n}, 16'h000E);

      // Invalid BCD and leading zeros
      bus.digits = 16'h00A5;
      run_to(50);
      check("lzb_d0", {9'h000, bus.seg_n}, 16'h0012);
      run_to(54);
      check("lzb_d1", {9'h000, bus.seg_n}, 16'h003F);
      run_to(58);
`ifdef SEG7_LZB_EN
      check("lzb_d2", {9'h000, bus.seg_n}, 16'h007F);
      check("lzb_d2_an", {12'h000, bus.an_n}, 16'h000B);
`else
      check("lzb_d2", {9'h000, bus.seg_n}, 16'h0040);
`endif
      run_to(62);
`ifdef SEG7_LZB_EN
      check("lzb_d3", {9'h000, bus.seg_n}, 16'h007F);
`else
      check("lzb_d3", {9'h000, bus.seg_n}, 16'h0040);
`endif

      // Blank for 6 edges across a frame boundary
      bus.digits = 16'h9081;
      run_to(63);
      bus.blank = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check("blank_an", {12'h000, bus.an_n}, 16'h000F);
      end
      check("blank_t", t, 16'd69);
      bus.blank = 1'b0;
      step();
      check("unblank_an", {12'h000, bus.an_n}, 16'h000D);

      // Randomized digits and blank
      for (int i = 0; i < 320; i++) begin
         if ($urandom_range(0, 6) == 0) begin
            bus.digits = 16'($urandom);
            if ($urandom_range(0, 2) == 0) bus.digits = bus.digits & 16'h00FF;
            if ($urandom_range(0, 3) == 0) bus.digits = bus.digits & 16'h0F0F;
         end
         bus.blank = ($urandom_range(0, 4) == 0);
         step();
      end
      bus.blank = 1'b0;

      // Mid-frame reset during the digit-2 slot
      bus.digits = 16'h1234;
      for (int i = 0; i < FRAME && (((t - 1) % FRAME) / DIV) != 2; i++) step();
      check("pre_reset_an", {12'h000, bus.an_n}, (((t - 1) % DIV) == 0) ? 16'h000F : 16'h000B);
      reset_n = 1'b0;
      #2;
      check_reset_vals("async_reset");
      @(posedge clk);
      #1;
      check_reset_vals("async_reset_hold");
      model_reset();
      reset_n = 1'b1;
      run_table();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
